// File: rtl/mcu_cmd_pkg.sv
// rtl/mcu_cmd_pkg.sv - shared command codes and FSM encoding for the MCU command decoder
//
// Contents:
//   CMD_*      command byte codes accepted on cmd_data
//   ST_*       memory-port FSM state encoding
//   cmd_decode maps a raw command byte to a known code, anything unknown becomes CMD_NOP

package mcu_cmd_pkg;

    localparam logic [7:0] CMD_NOP       = 8'h00;
    localparam logic [7:0] CMD_SETADDR   = 8'h01;
    localparam logic [7:0] CMD_WRITE     = 8'h02;
    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_SETMAPPER = 8'h04;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Unknown codes are stored as NOP so the rest of the decoder only ever
    // has to look at the five defined values.
    function automatic logic [7:0] cmd_decode(input logic [7:0] raw);
        logic [7:0] code;
        code = CMD_NOP;
        if (raw <= CMD_SETMAPPER) begin
            code = raw;
        end
        return code;
    endfunction

endpackage

// File: rtl/mcu_cmd.sv
// rtl/mcu_cmd.sv - MCU command/parameter decoder with address register and byte memory port
//
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   cmd_ready, cmd_data      1-clk strobe + first byte of an SPI message (command)
//   param_ready, param_data  1-clk strobe + each following byte (parameter)
//   spi_tx_data              byte the SPI slave shifts out on the next MISO transfer
//   mem_req/mem_we/mem_addr/mem_wdata   request to the SRAM arbiter, held until mem_ack
//   mem_ack, mem_rdata       1-clk completion strobe and read data from the arbiter
//   mapper                   mapper configuration register
//   overrun                  sticky flag: a parameter byte was dropped while memory was busy

module mcu_cmd
    import mcu_cmd_pkg::*;
#(
    parameter int ADDR_W   = 24,
    parameter bit ADDR_INC = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_ready,
    input  logic              param_ready,
    input  logic [7:0]        cmd_data,
    input  logic [7:0]        param_data,
    output logic [7:0]        spi_tx_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        mapper,
    output logic              overrun
);

    logic [0:0]        state;
    logic [7:0]        cmd_q;
    logic [1:0]        pcnt;
    logic [ADDR_W-1:0] addr_q;
    // A READ latched while a request is still in flight must wait for the
    // ack before its prefetch can go out.
    logic              rd_pending;
    logic [7:0]        cmd_dec;

    always_comb begin
        cmd_dec = cmd_decode(cmd_data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cmd_q       <= CMD_NOP;
            pcnt        <= 2'd0;
            addr_q      <= '0;
            rd_pending  <= 1'b0;
            spi_tx_data <= 8'h00;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= 8'h00;
            mapper      <= 8'h00;
            overrun     <= 1'b0;
        end else begin
            // Completion of the in-flight request. This only fires in BUSY,
            // while everything below that touches addr_q or issues a request
            // only fires in IDLE, so the two never fight over a register.
            if (state == ST_BUSY && mem_ack) begin
                state   <= ST_IDLE;
                mem_req <= 1'b0;
                if (ADDR_INC) begin
                    addr_q <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
                // The command register still holds the value from before this
                // edge, so a same-cycle cmd_ready does not suppress the update.
                if (!mem_we && cmd_q == CMD_READ) begin
                    spi_tx_data <= mem_rdata;
                end
            end

            if (cmd_ready) begin
                cmd_q   <= cmd_dec;
                pcnt    <= 2'd0;
                overrun <= 1'b0;
                if (cmd_dec == CMD_READ) begin
                    if (state == ST_IDLE) begin
                        state      <= ST_BUSY;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= addr_q;
                        rd_pending <= 1'b0;
                    end else begin
                        rd_pending <= 1'b1;
                    end
                end else begin
                    rd_pending <= 1'b0;
                end
            end else if (param_ready) begin
                if (state == ST_BUSY) begin
                    // Byte is lost; it is not counted as a parameter either.
                    overrun <= 1'b1;
                end else begin
                    if (pcnt != 2'd3) begin
                        pcnt <= pcnt + 2'd1;
                    end
                    case (cmd_q)
                        CMD_SETADDR: begin
                            if (pcnt != 2'd3) begin
                                addr_q <= {addr_q[ADDR_W-9:0], param_data};
                            end
                        end
                        CMD_SETMAPPER: begin
                            if (pcnt == 2'd0) begin
                                mapper <= param_data;
                            end
                        end
                        CMD_WRITE: begin
                            state     <= ST_BUSY;
                            mem_req   <= 1'b1;
                            mem_we    <= 1'b1;
                            mem_addr  <= addr_q;
                            mem_wdata <= param_data;
                        end
                        CMD_READ: begin
                            state      <= ST_BUSY;
                            mem_req    <= 1'b1;
                            mem_we     <= 1'b0;
                            mem_addr   <= addr_q;
                            rd_pending <= 1'b0;
                        end
                        default: begin
                        end
                    endcase
                end
            end else if (rd_pending && state == ST_IDLE) begin
                state      <= ST_BUSY;
                mem_req    <= 1'b1;
                mem_we     <= 1'b0;
                mem_addr   <= addr_q;
                rd_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mcu_cmd.sv
// tb/tb_mcu_cmd.sv - self-checking bench for mcu_cmd against a byte-level reference model

module tb_mcu_cmd;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_ready = 1'b0;
    logic        param_ready = 1'b0;
    logic [7:0]  cmd_data = 8'h00;
    logic [7:0]  param_data = 8'h00;
    logic [7:0]  spi_tx_data;
    logic        mem_req;
    logic        mem_we;
    logic [23:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_ack = 1'b0;
    logic [7:0]  mem_rdata = 8'h00;
    logic [7:0]  mapper;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int unsigned m_addr = 0;
    logic [7:0]  m_map = 8'h00;
    logic [7:0]  m_spi = 8'h00;
    logic        m_ovr = 1'b0;
    logic [7:0]  m_cmd = 8'h00;
    int          m_pc = 0;

    mcu_cmd #(.ADDR_W(24), .ADDR_INC(1'b1)) dut (
        .clk(clk), .rst(rst),
        .cmd_ready(cmd_ready), .param_ready(param_ready),
        .cmd_data(cmd_data), .param_data(param_data),
        .spi_tx_data(spi_tx_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .mapper(mapper), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [7:0] c);
        cmd_data  = c;
        cmd_ready = 1'b1;
        tick();
        cmd_ready = 1'b0;
        m_cmd = (c > 8'h04) ? 8'h00 : c;
        m_ovr = 1'b0;
        m_pc  = 0;
    endtask

    // Parameter byte delivered while memory is idle.
    task automatic send_param(input logic [7:0] p);
        param_data  = p;
        param_ready = 1'b1;
        tick();
        param_ready = 1'b0;
        if (m_cmd == 8'h01 && m_pc < 3) m_addr = ((m_addr << 8) | 32'(p)) & 32'hFF_FFFF;
        if (m_cmd == 8'h04 && m_pc == 0) m_map = p;
        m_pc++;
    endtask

    // Parameter byte delivered while a request is in flight: expected to be lost.
    task automatic drop_param(input logic [7:0] p);
        param_data  = p;
        param_ready = 1'b1;
        tick();
        param_ready = 1'b0;
        m_ovr = 1'b1;
    endtask

    // Wait for a request, check it, optionally issue a command mid-flight, then ack.
    task automatic serve(input string tag, input logic we, input logic [7:0] wd,
                         input int lat, input logic [7:0] rd, input int mid_cmd);
        int w;
        w = 0;
        while (!mem_req && w < 20) begin
            tick();
            w++;
        end
        chk({tag, "_req"}, 32'(mem_req), 32'd1);
        if (mem_req) begin
            chk({tag, "_addr"}, 32'(mem_addr), m_addr);
            chk({tag, "_we"}, 32'(mem_we), 32'(we));
            if (we) chk({tag, "_wdata"}, 32'(mem_wdata), 32'(wd));
            if (mid_cmd >= 0) send_cmd(8'(mid_cmd));
            repeat (lat) tick();
            chk({tag, "_hold"}, 32'(mem_req), 32'd1);
            mem_ack   = 1'b1;
            mem_rdata = rd;
            tick();
            mem_ack   = 1'b0;
            chk({tag, "_drop"}, 32'(mem_req), 32'd0);
            m_addr = (m_addr + 1) & 32'hFF_FFFF;
            if (!we && m_cmd == 8'h03) m_spi = rd;
            chk({tag, "_spi"}, 32'(spi_tx_data), 32'(m_spi));
        end
    endtask

    initial begin
        int kind, n;
        logic [7:0] b;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        chk("rst_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_spi", 32'(spi_tx_data), 32'd0);
        chk("rst_map", 32'(mapper), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        rst = 1'b0;
        tick();

        // 1: SETADDR 12 34 56, READ, ack AB
        send_cmd(8'h01);
        send_param(8'h12); send_param(8'h34); send_param(8'h56);
        send_cmd(8'h03);
        chk("t1_addr_const", 32'(mem_addr), 32'h12_3456);
        serve("t1_rd0", 1'b0, 8'h00, 2, 8'hAB, -1);
        chk("t1_spi_const", 32'(spi_tx_data), 32'hAB);
        send_param(8'h00);
        chk("t1_addr_inc", 32'(mem_addr), 32'h12_3457);
        serve("t1_rd1", 1'b0, 8'h00, 1, 8'h5A, -1);

        // 2: WRITE 11, 22 with ack latency 3
        send_cmd(8'h02);
        send_param(8'h11);
        serve("t2_w0", 1'b1, 8'h11, 3, 8'h00, -1);
        send_param(8'h22);
        serve("t2_w1", 1'b1, 8'h22, 3, 8'h00, -1);
        chk("t2_ovr", 32'(overrun), 32'd0);

        // 3: second WRITE byte during BUSY is dropped
        send_cmd(8'h02);
        send_param(8'h33);
        tick();
        drop_param(8'h44);
        chk("t3_ovr_set", 32'(overrun), 32'd1);
        serve("t3_w", 1'b1, 8'h33, 7, 8'h00, -1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_no_req", 32'(mem_req), 32'd0);
        end
        chk("t3_ovr_sticky", 32'(overrun), 32'(m_ovr));
        send_cmd(8'h00);
        chk("t3_ovr_clr", 32'(overrun), 32'd0);

        // 4: SETMAPPER 05 07, then unknown 0x7F with params
        send_cmd(8'h04);
        send_param(8'h05); send_param(8'h07);
        chk("t4_map", 32'(mapper), 32'h05);
        send_cmd(8'h7F);
        for (int i = 0; i < 3; i++) begin
            send_param(8'($urandom));
            chk("t4_unk_req", 32'(mem_req), 32'd0);
        end
        chk("t4_unk_map", 32'(mapper), 32'h05);
        send_cmd(8'h02);
        b = 8'($urandom);
        send_param(b);
        serve("t4_addr_kept", 1'b1, b, 0, 8'h00, -1);

        // 5: address wrap, then reset mid-transaction
        send_cmd(8'h01);
        send_param(8'hFF); send_param(8'hFF); send_param(8'hFF);
        send_cmd(8'h02);
        send_param(8'h9C);
        serve("t5_wtop", 1'b1, 8'h9C, 1, 8'h00, -1);
        send_param(8'h9D);
        chk("t5_wrap", 32'(mem_addr), 32'd0);
        serve("t5_w0", 1'b1, 8'h9D, 0, 8'h00, -1);
        send_param(8'h9E);
        chk("t5_req_before_rst", 32'(mem_req), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_req", 32'(mem_req), 32'd0);
        chk("t5_rst_we", 32'(mem_we), 32'd0);
        chk("t5_rst_addr", 32'(mem_addr), 32'd0);
        chk("t5_rst_wdata", 32'(mem_wdata), 32'd0);
        chk("t5_rst_map", 32'(mapper), 32'd0);
        chk("t5_rst_spi", 32'(spi_tx_data), 32'd0);
        tick();
        rst = 1'b0;
        m_addr = 0; m_map = 8'h00; m_spi = 8'h00; m_ovr = 1'b0; m_cmd = 8'h00; m_pc = 0;
        tick();

        // 6: NOP during a READ fetch leaves spi_tx_data alone
        send_cmd(8'h01);
        send_param(8'($urandom)); send_param(8'($urandom)); send_param(8'($urandom));
        send_cmd(8'h03);
        serve("t6_rd", 1'b0, 8'h00, 3, 8'hC3, 0);
        chk("t6_spi_kept", 32'(spi_tx_data), 32'h00);

        // READ latched while a WRITE is in flight prefetches after the ack
        send_cmd(8'h02);
        send_param(8'h66);
        serve("t7_w", 1'b1, 8'h66, 2, 8'h00, 3);
        serve("t7_pref", 1'b0, 8'h00, 1, 8'h7E, -1);

        // Randomised messages against the model
        for (int it = 0; it < 40; it++) begin
            kind = int'($urandom_range(0, 4));
            n    = int'($urandom_range(1, 4));
            case (kind)
                0: begin
                    send_cmd(8'h01);
                    for (int k = 0; k < n; k++) send_param(8'($urandom));
                end
                1: begin
                    send_cmd(8'h04);
                    for (int k = 0; k < n; k++) send_param(8'($urandom));
                end
                2: begin
                    send_cmd(8'h02);
                    for (int k = 0; k < n; k++) begin
                        b = 8'($urandom);
                        send_param(b);
                        serve("rnd_w", 1'b1, b, int'($urandom_range(0, 4)), 8'h00, -1);
                    end
                end
                3: begin
                    send_cmd(8'h03);
                    serve("rnd_r", 1'b0, 8'h00, int'($urandom_range(0, 4)), 8'($urandom), -1);
                    for (int k = 1; k < n; k++) begin
                        send_param(8'($urandom));
                        serve("rnd_rd", 1'b0, 8'h00, int'($urandom_range(0, 4)), 8'($urandom), -1);
                    end
                end
                default: begin
                    send_cmd(8'($urandom_range(5, 255)));
                    for (int k = 0; k < n; k++) begin
                        send_param(8'($urandom));
                        chk("rnd_unk_req", 32'(mem_req), 32'd0);
                    end
                end
            endcase
            chk("rnd_map", 32'(mapper), 32'(m_map));
            chk("rnd_ovr", 32'(overrun), 32'(m_ovr));
            chk("rnd_spi", 32'(spi_tx_data), 32'(m_spi));
            repeat (int'($urandom_range(0, 2))) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
